// File: rtl/cdc_hs_arbiter.sv
// Two-requester round-robin arbiter feeding a 4-phase req/ack handshake toward
// another clock domain, with a bounded wait for the acknowledge.
module cdc_hs_arbiter #(
  parameter int Width         = 16,
  parameter int TimeoutCycles = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req0_valid_i,
  input  logic [Width-1:0] req0_data_i,
  output logic             req0_ready_o,
  input  logic             req1_valid_i,
  input  logic [Width-1:0] req1_data_i,
  output logic             req1_ready_o,
  output logic             cdc_req_o,
  output logic [Width-1:0] cdc_data_o,
  output logic             cdc_src_o,
  input  logic             cdc_ack_i,
  output logic             busy_o,
  output logic             timeout_o
);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_RELEASE} state_t;

  localparam logic [15:0] CntLast = 16'(TimeoutCycles - 1);

  state_t           r_state;
  logic [15:0]      r_cnt;
  logic             r_rr_last;
  logic             r_req;
  logic [Width-1:0] r_data;
  logic             r_src;

  logic w_any_valid;
  logic w_grant_src;
  logic w_in_req;
  logic w_ack_hit;
  logic w_timeout_hit;

  assign w_any_valid = req0_valid_i | req1_valid_i;

  // On a tie the requester that did not win last time is served.
  always_comb begin
    w_grant_src = req1_valid_i;
    if (req0_valid_i && req1_valid_i) begin
      w_grant_src = ~r_rr_last;
    end
  end

  assign w_in_req      = (r_state == ST_REQ) && !rst_i;
  assign w_ack_hit     = w_in_req && cdc_ack_i;
  assign w_timeout_hit = w_in_req && !cdc_ack_i && (r_cnt == CntLast);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_rr_last <= 1'b1;
      r_req     <= 1'b0;
      r_data    <= '0;
      r_src     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any_valid) begin
            r_data    <= w_grant_src ? req1_data_i : req0_data_i;
            r_src     <= w_grant_src;
            r_rr_last <= w_grant_src;
            r_cnt     <= '0;
            r_req     <= 1'b1;
            r_state   <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (r_cnt != 16'hFFFF) begin
            r_cnt <= r_cnt + 16'd1;
          end
          // Ack takes priority over an expiring counter in the same cycle.
          if (cdc_ack_i || (r_cnt == CntLast)) begin
            r_req   <= 1'b0;
            r_state <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          if (!cdc_ack_i) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_req   <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign req0_ready_o = w_ack_hit && !r_src;
  assign req1_ready_o = w_ack_hit &&  r_src;
  assign timeout_o    = w_timeout_hit;
  assign cdc_req_o    = r_req;
  assign cdc_data_o   = r_data;
  assign cdc_src_o    = r_src;
  assign busy_o       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_cdc_hs_arbiter.sv
// Scoreboard bench for cdc_hs_arbiter: directed transfers with a scripted
// destination responder; a monitor pops expected transfers on every ready/timeout.
module tb_cdc_hs_arbiter;

  localparam int W  = 16;
  localparam int TO = 64;

  typedef struct packed {
    logic         to;
    logic         src;
    logic [W-1:0] data;
  } exp_t;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic         req0_valid_i, req1_valid_i;
  logic [W-1:0] req0_data_i, req1_data_i;
  logic         req0_ready_o, req1_ready_o;
  logic         cdc_req_o, cdc_src_o, busy_o, timeout_o;
  logic [W-1:0] cdc_data_o;
  logic         cdc_ack_i;

  exp_t         exp_q[$];
  logic [W-1:0] q0[$];
  logic [W-1:0] q1[$];

  int errors = 0;
  int checks = 0;
  int rdy0 = 0;
  int rdy1 = 0;
  int req_hi_cnt = 0;

  bit resp_en   = 1'b1;
  int ack_delay = 3;
  int rel_delay = 1;

  always #5 clk_i = ~clk_i;

  cdc_hs_arbiter #(.Width(W), .TimeoutCycles(TO)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .req0_valid_i (req0_valid_i),
    .req0_data_i  (req0_data_i),
    .req0_ready_o (req0_ready_o),
    .req1_valid_i (req1_valid_i),
    .req1_data_i  (req1_data_i),
    .req1_ready_o (req1_ready_o),
    .cdc_req_o    (cdc_req_o),
    .cdc_data_o   (cdc_data_o),
    .cdc_src_o    (cdc_src_o),
    .cdc_ack_i    (cdc_ack_i),
    .busy_o       (busy_o),
    .timeout_o    (timeout_o)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic push_exp(input logic to, input logic src, input logic [W-1:0] data);
    exp_t e;
    e.to = to; e.src = src; e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic wait_done(input string name, input int budget);
    int  n = 0;
    bit  ok = 1'b0;
    while (!ok && n < budget) begin
      @(negedge clk_i);
      n++;
      ok = (exp_q.size() == 0) && !busy_o && (q0.size() == 0) && (q1.size() == 0);
    end
    chk({name, "_done"}, {31'd0, ok}, 32'd1);
    $display("%s: finished after %0d cycles, %0d expected transfers left", name, n, exp_q.size());
  endtask

  // Requester drivers: present the head of each queue, pop on an observed ready.
  initial begin
    logic a0, a1;
    req0_valid_i = 1'b0; req1_valid_i = 1'b0;
    req0_data_i  = '0;   req1_data_i  = '0;
    forever begin
      @(negedge clk_i);
      a0 = req0_ready_o;
      a1 = req1_ready_o;
      @(posedge clk_i); #1;
      if (a0 && q0.size() > 0) void'(q0.pop_front());
      if (a1 && q1.size() > 0) void'(q1.pop_front());
      req0_valid_i = (q0.size() > 0);
      req0_data_i  = (q0.size() > 0) ? q0[0] : '0;
      req1_valid_i = (q1.size() > 0);
      req1_data_i  = (q1.size() > 0) ? q1[0] : '0;
    end
  end

  // Destination responder: raise ack ack_delay cycles into a request, drop it
  // rel_delay cycles after the request falls.
  initial begin
    int hi = 0;
    int lo = 0;
    cdc_ack_i = 1'b0;
    forever begin
      @(posedge clk_i); #1;
      if (rst_i || !resp_en) begin
        hi = 0; lo = 0; cdc_ack_i = 1'b0;
      end else if (cdc_req_o) begin
        lo = 0; hi++;
        if (hi >= ack_delay) cdc_ack_i = 1'b1;
      end else begin
        hi = 0;
        if (cdc_ack_i) begin
          lo++;
          if (lo >= rel_delay) begin
            cdc_ack_i = 1'b0; lo = 0;
          end
        end
      end
    end
  end

  initial forever begin
    @(negedge clk_i);
    if (cdc_req_o) req_hi_cnt++;
  end

  // Monitor / scoreboard.
  initial forever begin
    exp_t e;
    @(negedge clk_i);
    if (!cdc_req_o) chk("no_event_outside_req", {29'd0, req0_ready_o, req1_ready_o, timeout_o}, 32'd0);
    if (req0_ready_o || req1_ready_o || timeout_o) begin
      if (req0_ready_o) rdy0++;
      if (req1_ready_o) rdy1++;
      if (exp_q.size() == 0) begin
        chk("unexpected_event", {29'd0, timeout_o, req1_ready_o, req0_ready_o}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("xfer", {12'd0, timeout_o, req1_ready_o, req0_ready_o, cdc_src_o, cdc_data_o},
            {12'd0, e.to, (!e.to && e.src), (!e.to && !e.src), e.src, e.data});
        $display("xfer: src=%0d data=%h ready0=%0b ready1=%0b timeout=%0b (exp to=%0b src=%0d data=%h)",
                 cdc_src_o, cdc_data_o, req0_ready_o, req1_ready_o, timeout_o, e.to, e.src, e.data);
      end
    end
  end

  initial begin
    #(300000);
    $display("FAIL watchdog: simulation did not finish in time");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int hi0, r0b, r1b, n;
    // Reset state, sampled while reset is still asserted.
    rst_i = 1'b1;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_cdc_req", {31'd0, cdc_req_o}, 32'd0);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_data", {16'd0, cdc_data_o}, 32'd0);
    chk("rst_src", {31'd0, cdc_src_o}, 32'd0);
    chk("rst_ready_to", {29'd0, req0_ready_o, req1_ready_o, timeout_o}, 32'd0);
    @(posedge clk_i); #2;
    rst_i = 1'b0;

    // Single transfer from requester 0.
    ack_delay = 3; rel_delay = 1;
    q0.push_back(16'h1234);
    push_exp(1'b0, 1'b0, 16'h1234);
    wait_done("t1_single", 50);

    // Both requesters contending: rr_last is 0, so requester 1 goes first.
    @(posedge clk_i); #2;
    ack_delay = 2; rel_delay = 2;
    r0b = rdy0; r1b = rdy1;
    q0.push_back(16'hA000); q0.push_back(16'hA001);
    q1.push_back(16'hB000); q1.push_back(16'hB001);
    push_exp(1'b0, 1'b1, 16'hB000);
    push_exp(1'b0, 1'b0, 16'hA000);
    push_exp(1'b0, 1'b1, 16'hB001);
    push_exp(1'b0, 1'b0, 16'hA001);
    wait_done("t2_alternate", 200);
    chk("t2_ready0_count", rdy0 - r0b, 32'd2);
    chk("t2_ready1_count", rdy1 - r1b, 32'd2);

    // Ack never arrives: timeout after exactly TO request cycles.
    @(posedge clk_i); #2;
    resp_en = 1'b0; ack_delay = 3; rel_delay = 1;
    hi0 = req_hi_cnt;
    q0.push_back(16'hC0DE);
    push_exp(1'b1, 1'b0, 16'hC0DE);
    n = 0;
    do begin @(negedge clk_i); n++; end while (!timeout_o && n < 300);
    chk("t3_timeout_seen", {31'd0, timeout_o}, 32'd1);
    // Requester 0 keeps its word; requester 1 now pending must win next.
    q1.push_back(16'hB100);
    push_exp(1'b0, 1'b1, 16'hB100);
    push_exp(1'b0, 1'b0, 16'hC0DE);
    resp_en = 1'b1;
    @(posedge clk_i); #2;
    chk("t3_req_cycles", req_hi_cnt - hi0, 32'(TO));
    wait_done("t3_timeout_then_rr", 150);

    // Ack arrives on the very cycle the counter expires: ack wins.
    @(posedge clk_i); #2;
    ack_delay = TO; rel_delay = 1;
    hi0 = req_hi_cnt;
    q1.push_back(16'hD00D);
    push_exp(1'b0, 1'b1, 16'hD00D);
    wait_done("t4_ack_on_timeout", 150);
    chk("t4_req_cycles", req_hi_cnt - hi0, 32'(TO));

    // Reset in the middle of a request drops it silently.
    @(posedge clk_i); #2;
    ack_delay = 10; rel_delay = 1;
    q0.push_back(16'hE0E0);
    n = 0;
    do begin @(negedge clk_i); n++; end while (!cdc_req_o && n < 20);
    chk("t5_req_started", {31'd0, cdc_req_o}, 32'd1);
    repeat (2) @(negedge clk_i);
    q0.delete();
    @(posedge clk_i); #2;
    rst_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    chk("t5_rst_state", {13'd0, cdc_req_o, busy_o, cdc_src_o, cdc_data_o}, 32'd0);
    @(posedge clk_i); #2;
    rst_i = 1'b0;
    ack_delay = 2;
    q1.push_back(16'h5A5A);
    push_exp(1'b0, 1'b1, 16'h5A5A);
    wait_done("t5_after_reset", 100);

    // Ack held high long after release: no new grant until it falls.
    @(posedge clk_i); #2;
    ack_delay = 2; rel_delay = 11;
    q0.push_back(16'h7777);
    push_exp(1'b0, 1'b0, 16'h7777);
    n = 0;
    do begin @(negedge clk_i); n++; end while (!req0_ready_o && n < 50);
    chk("t6_ready_seen", {31'd0, req0_ready_o}, 32'd1);
    q1.push_back(16'h8888);
    push_exp(1'b0, 1'b1, 16'h8888);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      chk("t6_hold_release", {13'd0, busy_o, cdc_req_o, cdc_src_o, cdc_data_o},
          {13'd0, 1'b1, 1'b0, 1'b0, 16'h7777});
    end
    wait_done("t6_ack_held", 100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cdc_hs_arbiter.md
CDC_HS_ARBITER -- requirements
Module: cdc_hs_arbiter

Interface
REQ-001 Width, default 16, payload width in bits.
REQ-002 TimeoutCycles, default 64, max cycles in REQ waiting for ack; legal range 2..65535.
REQ-003 clk_i  in  1  single clock; all logic on rising edge.
REQ-004 rst_i  in  1  synchronous, active-high reset.
REQ-005 req0_valid_i  in  1  requester 0 has a word to send; held until req0_ready_o.
REQ-006 req0_data_i  in  Width  requester 0 payload.
REQ-007 req0_ready_o  out  1  one-cycle accept pulse to requester 0.
REQ-008 req1_valid_i, req1_data_i, req1_ready_o  same as REQ-005..007, requester 1.
REQ-009 cdc_req_o  out  1  4-phase request level to destination domain, registered.
REQ-010 cdc_data_o  out  Width  payload to destination, registered, stable while busy_o.
REQ-011 cdc_src_o  out  1  index of granted requester, registered.
REQ-012 cdc_ack_i  in  1  destination ack level, already passed through a 2-flop synchronizer outside this block.
REQ-013 busy_o  out  1  high when state != IDLE.
REQ-014 timeout_o  out  1  one-cycle pulse when a request is abandoned.

Function
REQ-015 FSM states IDLE, REQ, RELEASE; encoding free.
REQ-016 IDLE: if any valid, grant, latch winner data into cdc_data_o and index into cdc_src_o, clear timeout counter, next state REQ.
REQ-017 Arbitration: one valid -> that requester; both valid -> requester != rr_last; rr_last updated to winner on every grant.
REQ-018 cdc_req_o high exactly while state == REQ; first high cycle is the cycle after the grant (latency 1 from valid in IDLE).
REQ-019 REQ: counter increments by 1 each cycle, saturating; no wrap.
REQ-020 REQ with cdc_ack_i == 1: ready of granted requester high that same cycle (combinational from state, ack, cdc_src_o); next state RELEASE.
REQ-021 REQ with cdc_ack_i == 0 and counter == TimeoutCycles-1: timeout_o high that cycle, no ready pulse, next state RELEASE.
REQ-022 Ack and timeout in the same cycle: ack wins, no timeout_o.
REQ-023 RELEASE: cdc_req_o low; wait for cdc_ack_i == 0, then next state IDLE; no timeout in RELEASE.
REQ-024 Timed-out requester keeps valid; rr_last already points to it, so a pending other requester wins the next grant.
REQ-025 cdc_data_o and cdc_src_o change only on a grant in IDLE.
REQ-026 At most one readyX_o high in any cycle; never high outside REQ.
REQ-027 Valid dropped after grant (protocol violation): transfer completes from latched data; ready still pulses.
REQ-028 Minimum transfer: grant cycle + 1 REQ cycle + 1 RELEASE cycle = 3 cycles IDLE to IDLE.

Reset
REQ-029 rst_i high at a clock edge: state IDLE, cdc_req_o 0, cdc_data_o 0, cdc_src_o 0, counter 0, rr_last 1 (requester 0 wins first tie).
REQ-030 Reset during REQ/RELEASE: cdc_req_o low after that edge; in-flight transfer dropped without ready or timeout_o.
REQ-031 During reset all ready and timeout_o outputs are 0.

Verification
REQ-032 After reset, req0_valid_i=1 data 0x1234, ack rises 3 cycles after cdc_req_o -> cdc_data_o 0x1234, src 0, req0_ready_o one pulse in ack cycle, busy_o low after ack falls.
REQ-033 Both valid continuously, ack echoes req with 2-cycle delay -> grants alternate 0,1,0,1; each requester gets exactly one ready per transfer.
REQ-034 Ack held 0, TimeoutCycles=64 -> cdc_req_o high exactly 64 cycles, timeout_o one pulse on 64th, no ready, then IDLE.
REQ-035 Ack rises on the timeout cycle -> ready pulse, timeout_o stays 0.
REQ-036 rst_i asserted mid-REQ -> next cycle cdc_req_o 0, busy_o 0, cdc_data_o 0, no ready/timeout pulse; after release, req1 alone valid -> granted normally.
REQ-037 Ack held high after RELEASE entry for 10 cycles -> stays in RELEASE, cdc_req_o 0, no new grant until ack falls.
